// File: rtl/nco_multi_if.sv
// Config/sample bus of the multi-channel NCO: config writes and sweep tick in,
// sample burst and status out.
interface nco_multi_if #(
  parameter int CW    = 2,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
);
  logic             ce;
  logic             cfg_we;
  logic [CW-1:0]    cfg_ch;
  logic [ACC_W-1:0] cfg_freq;
  logic [1:0]       cfg_mode;
  logic             cfg_clr;
  logic             out_valid;
  logic [CW-1:0]    out_ch;
  logic [OUT_W-1:0] out_data;
  logic             busy;
  logic             overrun;

  modport master (
    output ce, cfg_we, cfg_ch, cfg_freq, cfg_mode, cfg_clr,
    input  out_valid, out_ch, out_data, busy, overrun
  );
  modport slave (
    input  ce, cfg_we, cfg_ch, cfg_freq, cfg_mode, cfg_clr,
    output out_valid, out_ch, out_data, busy, overrun
  );
endinterface

// File: rtl/nco_multi.sv
// Time-multiplexed multi-channel NCO: per-channel phase state, one sweep per ce,
// shared quarter-wave cosine ROM feeding a 2-register fold/output pipeline.
module nco_multi_chan #(
  parameter int ACC_W = 24,
  parameter int PW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [ACC_W-1:0] freq_i,
  input  logic [1:0]       mode_i,
  output logic [PW-1:0]    phase_o,
  output logic [1:0]       mode_o
);
  logic [ACC_W-1:0] acc_q, freq_q;
  logic [1:0]       mode_q;

  // clear beats the issue increment; freq/mode writes only affect later issues
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      freq_q <= '0;
      mode_q <= '0;
    end else begin
      if (wr_i) begin
        freq_q <= freq_i;
        mode_q <= mode_i;
      end
      if (wr_i && clr_i) acc_q <= '0;
      else if (inc_i)    acc_q <= acc_q + freq_q;
    end
  end

  assign phase_o = acc_q[ACC_W-1 -: PW];
  assign mode_o  = mode_q;
endmodule

module nco_multi #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 24,
  parameter int LUT_AW   = 8,
  parameter int OUT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  nco_multi_if.slave  io
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = LUT_AW + 2;

  typedef enum logic {S_IDLE, S_SWEEP} state_e;

  typedef struct packed {
    logic [CW-1:0]    ch;
    logic [1:0]       mode;
    logic [1:0]       quad;
    logic [OUT_W-2:0] rom;
    logic [OUT_W-1:0] saw;
  } s1_t;

  function automatic logic [OUT_W-2:0] rom_val(input int k);
    real amp, x;
    int  v;
    amp = real'(2 ** (OUT_W - 1)) - 0.5;
    x   = amp * $cos(3.14159265358979323846 * (real'(k) + 0.5) / real'(2 ** (LUT_AW + 1))) - 0.5;
    v   = $rtoi(x + 0.5);
    if (v < 0) v = 0;
    return (OUT_W-1)'(v);
  endfunction

  logic [OUT_W-2:0] rom [2**LUT_AW];
  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
    assign rom[k] = rom_val(k);
  end

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         ovr_q, ovr_d;
  logic [1:0]                   vld_pipe_q;
  s1_t                          s1_q, s1_d;
  logic [CW-1:0]                out_ch_q;
  logic [OUT_W-1:0]             out_data_q, data_d;
  logic                         issue;
  logic [CHANNELS-1:0][PW-1:0]  phase_all;
  logic [CHANNELS-1:0][1:0]     mode_all;
  logic [PW-1:0]                ph, ps;
  logic [1:0]                   md;
  logic [LUT_AW-1:0]            idx;
  logic [OUT_W-1:0]             saw;

  assign issue = (state_q == S_SWEEP);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    nco_multi_chan #(.ACC_W(ACC_W), .PW(PW)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (io.cfg_we && (io.cfg_ch == CW'(c))),
      .clr_i   (io.cfg_clr),
      .inc_i   (issue && (cnt_q == CW'(c))),
      .freq_i  (io.cfg_freq),
      .mode_i  (io.cfg_mode),
      .phase_o (phase_all[c]),
      .mode_o  (mode_all[c])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q | (io.ce && issue);
    case (state_q)
      S_IDLE: if (io.ce) begin
        state_d = S_SWEEP;
        cnt_d   = '0;
      end
      S_SWEEP: begin
        if (cnt_q == CW'(CHANNELS - 1)) state_d = S_IDLE;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // sin is cos delayed by a quarter turn; odd quadrants read the table mirrored
  assign ph  = phase_all[cnt_q];
  assign md  = mode_all[cnt_q];
  assign ps  = (md == 2'd1) ? ph - {2'b01, {LUT_AW{1'b0}}} : ph;
  assign idx = ps[LUT_AW] ? ~ps[LUT_AW-1:0] : ps[LUT_AW-1:0];

  if (OUT_W <= PW) begin : g_saw_trunc
    assign saw = ps[PW-1 -: OUT_W];
  end else begin : g_saw_pad
    assign saw = {ps, {(OUT_W-PW){1'b0}}};
  end

  always_comb begin
    s1_d      = '0;
    s1_d.ch   = cnt_q;
    s1_d.mode = md;
    s1_d.quad = ps[PW-1 -: 2];
    s1_d.rom  = rom[idx];
    s1_d.saw  = saw;
  end

  // H+Q is {1,Q}; H-1-Q is {0,~Q}
  always_comb begin
    case (s1_q.mode)
      2'd2:    data_d = {OUT_W{~s1_q.quad[1]}};
      2'd3:    data_d = s1_q.saw;
      default: data_d = (s1_q.quad == 2'd1 || s1_q.quad == 2'd2) ? {1'b0, ~s1_q.rom}
                                                                   : {1'b1, s1_q.rom};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ovr_q      <= 1'b0;
      vld_pipe_q <= '0;
      s1_q       <= '0;
      out_ch_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovr_q      <= ovr_d;
      vld_pipe_q <= {vld_pipe_q[0], issue};
      s1_q       <= s1_d;
      if (vld_pipe_q[0]) begin
        out_ch_q   <= s1_q.ch;
        out_data_q <= data_d;
      end
    end
  end

  assign io.out_valid = vld_pipe_q[1];
  assign io.out_ch    = out_ch_q;
  assign io.out_data  = out_data_q;
  assign io.busy      = issue;
  assign io.overrun   = ovr_q;
endmodule

// File: tb/tb_nco_multi.sv
// Scoreboard bench for nco_multi: a behavioural channel model pushes expected
// samples (channel, value, arrival cycle) per tick; a monitor pops on out_valid.
module tb_nco_multi;
  localparam int CH = 4, ACC_W = 24, LUT_AW = 8, OUT_W = 8, CW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nco_multi_if #(.CW(CW), .ACC_W(ACC_W), .OUT_W(OUT_W)) io ();
  nco_multi #(.CHANNELS(CH), .ACC_W(ACC_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, fails = 0;
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s act=%0d exp=%0d cyc=%0d", tag, act, exp, cyc);
    end
  endtask

  typedef struct {int ch; int data; int cyc;} exp_t;
  exp_t sb[$];

  logic [ACC_W-1:0] m_acc [CH];
  logic [ACC_W-1:0] m_freq[CH];
  logic [1:0]       m_mode[CH];

  function automatic int qtab(input int k);
    real x;
    int  v;
    x = 127.5 * $cos(3.141592653589793 * (real'(k) + 0.5) / 512.0) - 0.5;
    v = $rtoi($floor(x + 0.5));
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int exp_sample(input logic [ACC_W-1:0] a, input logic [1:0] m);
    logic [9:0] p, q_ph;
    int quad, i, idx, qv;
    p = a[23:14];
    if (m == 2'd2) return p[9] ? 0 : 255;
    if (m == 2'd3) return int'(p[9:2]);
    q_ph = (m == 2'd1) ? p - 10'd256 : p;
    quad = int'(q_ph[9:8]);
    i    = int'(q_ph[7:0]);
    idx  = (quad % 2 == 1) ? 255 - i : i;
    qv   = qtab(idx);
    return (quad == 0 || quad == 3) ? 128 + qv : 127 - qv;
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset && io.out_valid) begin
      if (sb.size() == 0) chk("extra_valid", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("out_ch", int'(io.out_ch), mon_e.ch);
        chk("out_data", int'(io.out_data), mon_e.data);
        chk("latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic do_reset();
    reset       = 1'b1;
    io.ce       = 1'b0;
    io.cfg_we   = 1'b0;
    io.cfg_clr  = 1'b0;
    io.cfg_ch   = '0;
    io.cfg_freq = '0;
    io.cfg_mode = '0;
    sb.delete();
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = '0; m_freq[c] = '0; m_mode[c] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg(input int ch, input logic [ACC_W-1:0] f, input int md, input bit clr);
    io.cfg_we   = 1'b1;
    io.cfg_ch   = CW'(ch);
    io.cfg_freq = f;
    io.cfg_mode = 2'(md);
    io.cfg_clr  = clr;
    @(negedge clk);
    io.cfg_we  = 1'b0;
    io.cfg_clr = 1'b0;
    m_freq[ch] = f;
    m_mode[ch] = 2'(md);
    if (clr) m_acc[ch] = '0;
  endtask

  // ce at cycle k; optional second ce at k+2 and a clear landing on clr_ch's issue cycle
  task automatic tick(input int clr_ch, input bit second_ce);
    int k;
    exp_t e;
    k = cyc;
    io.ce = 1'b1;
    for (int c = 0; c < CH; c++) begin
      e.ch = c; e.data = exp_sample(m_acc[c], m_mode[c]); e.cyc = k + 3 + c;
      sb.push_back(e);
    end
    for (int c = 0; c < CH; c++)
      m_acc[c] = (c == clr_ch) ? '0 : m_acc[c] + m_freq[c];
    @(negedge clk);
    for (int j = 1; j <= CH + 1; j++) begin
      io.ce = second_ce && (j == 2);
      if (clr_ch >= 0 && j == 1 + clr_ch) begin
        io.cfg_we = 1'b1; io.cfg_clr = 1'b1; io.cfg_ch = CW'(clr_ch);
        io.cfg_freq = m_freq[clr_ch]; io.cfg_mode = m_mode[clr_ch];
      end else begin
        io.cfg_we = 1'b0; io.cfg_clr = 1'b0;
      end
      if (j <= CH) chk("busy", int'(io.busy), 1);
      else         chk("busy_end", int'(io.busy), 0);
      if (second_ce) chk("overrun", int'(io.overrun), (j >= 3) ? 1 : 0);
      @(negedge clk);
    end
    io.ce = 1'b0; io.cfg_we = 1'b0; io.cfg_clr = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    do_reset();

    // idle after reset
    repeat (20) begin
      chk("idle_valid", int'(io.out_valid), 0);
      chk("idle_busy", int'(io.busy), 0);
      chk("idle_ovr", int'(io.overrun), 0);
      chk("idle_data", int'(io.out_data), 0);
      @(negedge clk);
    end

    // ch0 cos quarter-turn steps, others static
    cfg(0, 24'h40_0000, 0, 1'b0);
    repeat (5) tick(-1, 1'b0);
    drain();

    // sin / square / saw
    do_reset();
    cfg(1, 24'h40_0000, 1, 1'b0);
    cfg(2, 24'h40_0000, 2, 1'b0);
    cfg(3, 24'h40_0000, 3, 1'b0);
    repeat (4) tick(-1, 1'b0);
    drain();

    // ce while busy: single burst, sticky overrun
    do_reset();
    cfg(0, 24'h40_0000, 0, 1'b0);
    tick(-1, 1'b1);
    repeat (2) tick(-1, 1'b0);
    drain();
    chk("ovr_sticky", int'(io.overrun), 1);
    do_reset();
    chk("ovr_cleared", int'(io.overrun), 0);

    // clear on the issue cycle of ch2
    cfg(2, 24'h40_0000, 3, 1'b0);
    tick(-1, 1'b0);
    tick(2, 1'b0);
    tick(-1, 1'b0);
    drain();

    // random configs with back-to-back ticks
    for (int n = 0; n < 20; n++) begin
      cfg($urandom_range(0, CH-1), ACC_W'($urandom), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(1, 3)) tick(-1, 1'b0);
    end
    drain();

    // reset mid-sweep aborts the burst
    cfg(0, 24'h12_3456, 0, 1'b0);
    io.ce = 1'b1;
    @(negedge clk);
    io.ce = 1'b0;
    @(negedge clk);
    do_reset();
    repeat (10) begin
      chk("abort_valid", int'(io.out_valid), 0);
      chk("abort_busy", int'(io.busy), 0);
      @(negedge clk);
    end
    chk("abort_data", int'(io.out_data), 0);
    tick(-1, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
